// File: rtl/rocketcpu_wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: three masters share one slave bus.
// One arbitration cycle in IDLE, then the granted master owns the bus
// until the slave acks, the master aborts, or the wait counter expires.
module rocketcpu_wb_rr_arbiter #(
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        i_wb_clk,
    input  logic        reset,
    input  logic [95:0] i_m_adr,
    input  logic [95:0] i_m_dat,
    input  logic [11:0] i_m_sel,
    input  logic [2:0]  i_m_we,
    input  logic [2:0]  i_m_cyc,
    output logic [31:0] o_m_rdt,
    output logic [2:0]  o_m_ack,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    output logic [2:0]  o_grant,
    output logic        o_timeout,
    output logic [7:0]  o_timeout_cnt
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  BUSY     = 1'b1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [0:0]  state;
    logic [2:0]  grant;
    logic [1:0]  last;
    logic [1:0]  gidx;
    logic [15:0] wait_cnt;
    logic [7:0]  tmo_cnt;
    logic [2:0]  winner;
    logic        gcyc;
    logic        tmo;

    // Round-robin pick: scan from the master after the last owner; lowest offset wins.
    always_comb begin
        winner = '0;
        for (int i = 2; i >= 0; i--) begin
            int c;
            c = (int'(last) + 1 + i) % 3;
            if (i_m_cyc[c]) begin
                winner    = '0;
                winner[c] = 1'b1;
            end
        end
    end

    // Encode the one-hot grant and mux the granted master onto the slave bus.
    always_comb begin
        gidx    = 2'd0;
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        gcyc    = 1'b0;
        if (state == BUSY) begin
            case (grant)
                3'b001: begin
                    gidx = 2'd0; o_s_adr = i_m_adr[31:0]; o_s_dat = i_m_dat[31:0];
                    o_s_sel = i_m_sel[3:0]; o_s_we = i_m_we[0]; gcyc = i_m_cyc[0];
                end
                3'b010: begin
                    gidx = 2'd1; o_s_adr = i_m_adr[63:32]; o_s_dat = i_m_dat[63:32];
                    o_s_sel = i_m_sel[7:4]; o_s_we = i_m_we[1]; gcyc = i_m_cyc[1];
                end
                3'b100: begin
                    gidx = 2'd2; o_s_adr = i_m_adr[95:64]; o_s_dat = i_m_dat[95:64];
                    o_s_sel = i_m_sel[11:8]; o_s_we = i_m_we[2]; gcyc = i_m_cyc[2];
                end
                default: begin
                    gidx = 2'd0;
                end
            endcase
        end
    end

    // Timeout fires only when no real ack arrives, so a late ack always wins the race.
    // Acks and the timeout pulse are masked while reset is asserted.
    always_comb begin
        tmo       = gcyc && !i_s_ack && (wait_cnt == TMO_LAST);
        o_s_cyc   = gcyc;
        o_m_ack   = (gcyc && (i_s_ack || tmo) && !reset) ? grant : 3'b000;
        o_m_rdt   = tmo ? TIMEOUT_DATA : i_s_rdt;
        o_timeout = tmo && !reset;
    end

    // Arbitration/transfer state machine with wait and timeout counters.
    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= 2'd2;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_m_cyc) begin
                        grant    <= winner;
                        state    <= BUSY;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    if (!gcyc || i_s_ack || tmo) begin
                        state <= IDLE;
                        grant <= '0;
                        last  <= gidx;
                        if (tmo && (tmo_cnt != 8'hFF))
                            tmo_cnt <= tmo_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign o_grant       = grant;
    assign o_timeout_cnt = tmo_cnt;

endmodule

// File: tb/tb_rocketcpu_wb_rr_arbiter.sv
// Directed bench for the round-robin Wishbone arbiter (TIMEOUT=4).
module tb_rocketcpu_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] m_adr, m_dat;
    logic [11:0] m_sel;
    logic [2:0]  m_we, m_cyc;
    logic [31:0] s_rdt;
    logic        s_ack;
    logic [31:0] m_rdt, s_adr, s_dat;
    logic [2:0]  m_ack, grant;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, timeout;
    logic [7:0]  timeout_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    rocketcpu_wb_rr_arbiter #(.TIMEOUT(4)) dut (
        .i_wb_clk(clk), .reset(reset),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
        .o_m_rdt(m_rdt), .o_m_ack(m_ack),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_cyc(s_cyc),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack),
        .o_grant(grant), .o_timeout(timeout), .o_timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  order [4];
    logic [31:0] adrs  [3];

    initial begin
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        adrs  = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
        reset = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0;
        s_rdt = '0; s_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_scyc", 32'(s_cyc), 0);
        check("rst_ack", 32'(m_ack), 0);
        check("rst_tmo", 32'(timeout), 0);
        check("rst_tcnt", 32'(timeout_cnt), 0);

        // Single read from m1, slave acks on the third BUSY cycle
        m_adr = {32'h0, 32'h0010_0000, 32'h0};
        m_sel = 12'h0F0;
        m_cyc = 3'b010;
        tick();
        check("single_grant", 32'(grant), 32'h2);
        check("single_scyc", 32'(s_cyc), 1);
        check("single_sadr", s_adr, 32'h0010_0000);
        check("single_ssel", 32'(s_sel), 32'hF);
        check("single_noack", 32'(m_ack), 0);
        tick();
        check("single_wait", 32'(m_ack), 0);
        tick();
        s_ack = 1'b1; s_rdt = 32'h1234_5678;
        #1;
        check("single_ack", 32'(m_ack), 32'h2);
        check("single_rdt", m_rdt, 32'h1234_5678);
        check("single_tmo", 32'(timeout), 0);
        tick();
        s_ack = 1'b0; m_cyc = 3'b000;
        #1;
        check("single_idle_grant", 32'(grant), 0);
        check("single_idle_scyc", 32'(s_cyc), 0);
        check("single_idle_sadr", s_adr, 0);

        // Contention: reset so m0 wins first, then order m0,m1,m2,m0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_adr = {adrs[2], adrs[1], adrs[0]};
        m_cyc = 3'b111;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("cont%0d_grant", t), 32'(grant), 32'(order[t]));
            check($sformatf("cont%0d_noack", t), 32'(m_ack), 0);
            tick();
            s_ack = 1'b1;
            #1;
            check($sformatf("cont%0d_ack", t), 32'(m_ack), 32'(order[t]));
            check($sformatf("cont%0d_sadr", t), s_adr,
                  (order[t] == 3'b001) ? adrs[0] : (order[t] == 3'b010) ? adrs[1] : adrs[2]);
            tick();
            s_ack = 1'b0;
            #1;
            check($sformatf("cont%0d_gap", t), 32'(grant), 0);
        end
        m_cyc = 3'b000;

        // Timeout: m2 alone, slave silent (last=0 so m2 is picked)
        m_cyc = 3'b100;
        tick();
        check("tmo_grant", 32'(grant), 32'h4);
        check("tmo_b1", 32'(timeout), 0);
        tick();
        tick();
        check("tmo_b3_ack", 32'(m_ack), 0);
        tick();
        check("tmo_ack", 32'(m_ack), 32'h4);
        check("tmo_rdt", m_rdt, 32'hDEAD_BEEF);
        check("tmo_pulse", 32'(timeout), 1);
        tick();
        m_cyc = 3'b000;
        #1;
        check("tmo_cnt", 32'(timeout_cnt), 1);
        check("tmo_pulse_off", 32'(timeout), 0);
        check("tmo_idle", 32'(grant), 0);

        // Ack/timeout race on the fourth BUSY cycle (m0 picked, last=2)
        m_cyc = 3'b001;
        tick();
        check("race_grant", 32'(grant), 32'h1);
        tick(); tick(); tick();
        s_ack = 1'b1; s_rdt = 32'hA5A5_A5A5;
        #1;
        check("race_ack", 32'(m_ack), 32'h1);
        check("race_rdt", m_rdt, 32'hA5A5_A5A5);
        check("race_tmo", 32'(timeout), 0);
        tick();
        s_ack = 1'b0; m_cyc = 3'b000;
        #1;
        check("race_cnt", 32'(timeout_cnt), 1);

        // Ack while idle is ignored
        s_ack = 1'b1;
        #1;
        check("idle_ack", 32'(m_ack), 0);
        s_ack = 1'b0;

        // Abort then reset mid-transfer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cyc = 3'b011;
        tick();
        check("abort_grant0", 32'(grant), 32'h1);
        tick();
        m_cyc = 3'b010; s_ack = 1'b1;
        #1;
        check("abort_scyc", 32'(s_cyc), 0);
        check("abort_noack", 32'(m_ack), 0);
        tick();
        s_ack = 1'b0;
        #1;
        check("abort_idle", 32'(grant), 0);
        check("abort_tcnt", 32'(timeout_cnt), 0);
        tick();
        check("abort_grant1", 32'(grant), 32'h2);
        tick();
        reset = 1'b1; s_ack = 1'b1;
        #1;
        check("rst_dom_ack", 32'(m_ack), 0);
        tick();
        reset = 1'b0; s_ack = 1'b0; m_cyc = 3'b011;
        #1;
        check("rst_mid_scyc", 32'(s_cyc), 0);
        check("rst_mid_grant", 32'(grant), 0);
        tick();
        check("rst_next_grant", 32'(grant), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
